// File: rtl/dual_filt_pkg.sv
// Shared types and sizing helpers for the dual-channel input sync/glitch filter.
// The optional event counter is enabled with DUALFILT_EVCNT_EN.
package dual_filt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } filt_state_t;

  localparam int EVCNT_W = 4;

  // Qualification counter must be able to hold values 0..filt_len.
  function automatic int cnt_width(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/dual_input_sync_filter_chan.sv
// One channel: synchroniser chain, glitch-qualification FSM, edge pulses,
// sticky PEND flag and (when DUALFILT_EVCNT_EN is defined) a saturating event count.
module sync_filter_chan
  import dual_filt_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_LVL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic ack,
  output logic f,
  output logic rise,
  output logic fall,
  output logic pend
`ifdef DUALFILT_EVCNT_EN
  ,
  output logic [EVCNT_W-1:0] evcnt
`endif
);

  localparam int            CW   = cnt_width(FILT_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  filt_state_t            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   f_q, f_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   pend_q, pend_d;
  logic                   s;
  logic                   change;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s != f_q) begin
          if (FILT_LEN == 1) begin
            f_d = s;
          end else begin
            state_d = QUAL;
            cnt_d   = CW'(1);
          end
        end
      end
      QUAL: begin
        if (s == f_q) begin
          // Level fell back before qualifying: treat as a glitch.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          f_d     = s;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    change = (f_d != f_q);
    rise_d = change & f_d;
    fall_d = change & ~f_d;
    // A new event outranks a simultaneous acknowledge.
    if (change) begin
      pend_d = 1'b1;
    end else if (ack) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RST_LVL}};
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign f    = f_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign pend = pend_q;

`ifdef DUALFILT_EVCNT_EN
  localparam logic [EVCNT_W-1:0] EVCNT_MAX = '1;

  logic [EVCNT_W-1:0] evcnt_q, evcnt_d;

  always_comb begin
    evcnt_d = evcnt_q;
    if (change) begin
      if (ack) begin
        evcnt_d = EVCNT_W'(1);
      end else if (evcnt_q != EVCNT_MAX) begin
        evcnt_d = evcnt_q + EVCNT_W'(1);
      end
    end else if (ack) begin
      evcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evcnt_q <= '0;
    end else begin
      evcnt_q <= evcnt_d;
    end
  end

  assign evcnt = evcnt_q;
`endif

endmodule

// File: rtl/dual_input_sync_filter.sv
// Two independent sync/glitch-filter channels for the twin-inverter Q1/Q2 inputs.
// Define DUALFILT_EVCNT_EN to add the EVCNT1/EVCNT2 event-count outputs.
module dual_input_sync_filter
  import dual_filt_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_LVL     = 1'b0
) (
  input  logic CLK,
  input  logic RESETL,
  input  logic I1,
  input  logic I2,
  input  logic ACK1,
  input  logic ACK2,
  output logic F1,
  output logic F2,
  output logic RISE1,
  output logic RISE2,
  output logic FALL1,
  output logic FALL2,
  output logic PEND1,
  output logic PEND2
`ifdef DUALFILT_EVCNT_EN
  ,
  output logic [EVCNT_W-1:0] EVCNT1,
  output logic [EVCNT_W-1:0] EVCNT2
`endif
);

  sync_filter_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .RST_LVL    (RST_LVL)
  ) u_chan1 (
    .clk  (CLK),
    .rst_n(RESETL),
    .i_raw(I1),
    .ack  (ACK1),
    .f    (F1),
    .rise (RISE1),
    .fall (FALL1),
    .pend (PEND1)
`ifdef DUALFILT_EVCNT_EN
    ,
    .evcnt(EVCNT1)
`endif
  );

  sync_filter_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .RST_LVL    (RST_LVL)
  ) u_chan2 (
    .clk  (CLK),
    .rst_n(RESETL),
    .i_raw(I2),
    .ack  (ACK2),
    .f    (F2),
    .rise (RISE2),
    .fall (FALL2),
    .pend (PEND2)
`ifdef DUALFILT_EVCNT_EN
    ,
    .evcnt(EVCNT2)
`endif
  );

endmodule

// File: tb/tb_dual_input_sync_filter.sv
// Scoreboard bench: stimulus queues expected RISE/FALL pulses with their cycle;
// a negedge monitor pops and compares whenever a pulse appears.
module tb_dual_input_sync_filter;

  logic CLK = 1'b0;
  logic RESETL, I1, I2, ACK1, ACK2;
  logic F1, F2, RISE1, RISE2, FALL1, FALL2, PEND1, PEND2;
`ifdef DUALFILT_EVCNT_EN
  logic [3:0] EVCNT1, EVCNT2;
`endif

  dual_input_sync_filter #(
    .SYNC_STAGES(2),
    .FILT_LEN   (4),
    .RST_LVL    (1'b0)
  ) dut (
    .CLK   (CLK),
    .RESETL(RESETL),
    .I1    (I1),
    .I2    (I2),
    .ACK1  (ACK1),
    .ACK2  (ACK2),
    .F1    (F1),
    .F2    (F2),
    .RISE1 (RISE1),
    .RISE2 (RISE2),
    .FALL1 (FALL1),
    .FALL2 (FALL2),
    .PEND1 (PEND1),
    .PEND2 (PEND2)
`ifdef DUALFILT_EVCNT_EN
    ,
    .EVCNT1(EVCNT1),
    .EVCNT2(EVCNT2)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit is_rise;
    int at;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("check %s: %0d ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic pop_front(input int ch);
    if (ch == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endtask

  task automatic mon(input int ch, input logic r, input logic fa, input logic p, input logic fl);
    ev_t e;
    int  n;
    n = (ch == 1) ? q1.size() : q2.size();
    while (n > 0) begin
      e = (ch == 1) ? q1[0] : q2[0];
      if (e.at >= cyc) break;
      checks++;
      errors++;
      $display("FAIL ch%0d missed pulse: got none, expected %s at cycle %0d", ch,
               e.is_rise ? "RISE" : "FALL", e.at);
      pop_front(ch);
      n--;
    end
    if (r || fa) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL ch%0d unexpected pulse: got rise=%0b fall=%0b, expected none (cycle %0d)",
                 ch, r, fa, cyc);
      end else begin
        e = (ch == 1) ? q1[0] : q2[0];
        pop_front(ch);
        check($sformatf("ch%0d pulse kind {rise,fall}", ch), {30'd0, r, fa}, {30'd0, e.is_rise, ~e.is_rise});
        check($sformatf("ch%0d pulse cycle", ch), cyc, e.at);
        check($sformatf("ch%0d F at pulse", ch), {31'd0, fl}, {31'd0, e.is_rise});
        check($sformatf("ch%0d PEND at pulse", ch), {31'd0, p}, 32'd1);
      end
    end
  endtask

  always @(negedge CLK) begin
    mon(1, RISE1, FALL1, PEND1, F1);
    mon(2, RISE2, FALL2, PEND2, F2);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_ack1();
    ACK1 = 1'b1;
    wait_cyc(1);
    ACK1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    RESETL = 1'b1;
    I1 = 1'b0; I2 = 1'b0; ACK1 = 1'b0; ACK2 = 1'b0;
    #1 RESETL = 1'b0;

    // Inputs toggling under reset must not reach any output.
    for (int k = 0; k < 4; k++) begin
      wait_cyc(1);
      I1 = ~I1;
      I2 = (k > 1);
      check("outputs under reset", {24'd0, F1, F2, RISE1, RISE2, FALL1, FALL2, PEND1, PEND2}, 32'd0);
    end
    wait_cyc(1);
    I1 = 1'b0; I2 = 1'b0; RESETL = 1'b1;
    wait_cyc(8);
    check("outputs after release", {24'd0, F1, F2, RISE1, RISE2, FALL1, FALL2, PEND1, PEND2}, 32'd0);

    // Qualified rise on ch1: F1 changes at edge 6.
    t0 = cyc;
    I1 = 1'b1;
    q1.push_back('{is_rise: 1'b1, at: t0 + 6});
    wait_cyc(5);
    check("F1 before edge 6", {31'd0, F1}, 32'd0);
    wait_cyc(5);
    check("F1 after rise", {31'd0, F1}, 32'd1);
    check("PEND1 after rise", {31'd0, PEND1}, 32'd1);
    check("ch2 untouched", {29'd0, F2, PEND2, RISE2}, 32'd0);

    // ACK alone clears PEND; a second ACK with PEND=0 does nothing.
    pulse_ack1();
    check("PEND1 after ack", {31'd0, PEND1}, 32'd0);
    pulse_ack1();
    check("PEND1 after idle ack", {31'd0, PEND1}, 32'd0);
    check("F1 after idle ack", {31'd0, F1}, 32'd1);

    // 3-cycle low glitch is rejected.
    I1 = 1'b0;
    wait_cyc(3);
    I1 = 1'b1;
    wait_cyc(12);
    check("F1 after glitch", {31'd0, F1}, 32'd1);
    check("PEND1 after glitch", {31'd0, PEND1}, 32'd0);

    // 4-cycle low pulse qualifies; ACK lands on the same edge as the FALL.
    t0 = cyc;
    I1 = 1'b0;
    q1.push_back('{is_rise: 1'b0, at: t0 + 6});
    q1.push_back('{is_rise: 1'b1, at: t0 + 10});
    wait_cyc(4);
    I1 = 1'b1;
    wait_cyc(1);
    ACK1 = 1'b1;
    wait_cyc(1);
    ACK1 = 1'b0;
    check("PEND1 ack vs new fall", {31'd0, PEND1}, 32'd1);
    wait_cyc(8);
    check("F1 after 4-cycle pulse", {31'd0, F1}, 32'd1);

    // Reset during ch2 qualification (cnt=2): partial count discarded.
    t0 = cyc;
    I2 = 1'b1;
    wait_cyc(4);
    RESETL = 1'b0;
    wait_cyc(2);
    RESETL = 1'b1;
    t1 = cyc;
    q1.push_back('{is_rise: 1'b1, at: t1 + 6});
    q2.push_back('{is_rise: 1'b1, at: t1 + 6});
    wait_cyc(1);
    check("outputs right after reset", {28'd0, F1, F2, PEND1, PEND2}, 32'd0);
    wait_cyc(9);
    check("F2 after requalify", {31'd0, F2}, 32'd1);
    check("PEND2 after requalify", {31'd0, PEND2}, 32'd1);

    ACK1 = 1'b1; ACK2 = 1'b1;
    wait_cyc(1);
    ACK1 = 1'b0; ACK2 = 1'b0;
    check("PEND both after ack", {30'd0, PEND1, PEND2}, 32'd0);

`ifdef DUALFILT_EVCNT_EN
    check("EVCNT1 after ack", {28'd0, EVCNT1}, 32'd0);
    for (int k = 0; k < 17; k++) begin
      t0 = cyc;
      I1 = ~I1;
      q1.push_back('{is_rise: I1, at: t0 + 6});
      wait_cyc(6);
    end
    wait_cyc(2);
    check("EVCNT1 saturated", {28'd0, EVCNT1}, 32'd15);
    check("EVCNT2 idle", {28'd0, EVCNT2}, 32'd0);
    pulse_ack1();
    check("EVCNT1 after ack", {28'd0, EVCNT1}, 32'd0);
    check("PEND1 after evcnt ack", {31'd0, PEND1}, 32'd0);
`endif

    wait_cyc(10);
    check("ch1 expected pulses left", q1.size(), 32'd0);
    check("ch2 expected pulses left", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
